timer_sched: RTL and testbench
==============================

Name: timer_sched

Overview:
- Shares one Timer instance between NREQ requesters, for example interrupt sources or peripheral delay users.
- Arbitrates the requesters round-robin, latches the winner's tick count and programs the shared timer.
- Sequences the load/run/expire cycle and returns a per-requester completion pulse.
- Sits between requesting blocks and the shared Timer. It drives the Timer's Load, Rst and En inputs and observes its End output.

Parameters:
- N, 32, timer width in bits; also the width of each requester's tick count.
- NREQ, 4, number of requesters (2..16).
- IW, 2, index width, equal to clog2(NREQ).

Ports:
- Clk  input  1  system clock; rising edge.
- Rst  input  1  asynchronous, active-low reset.
- Pwr_off  input  1  synchronous power-off; forces the block to idle and clears its outputs.
- Req  input  NREQ  level request per requester; held until Done or until the requester abandons the request.
- Ticks  input  NREQ*N  flattened tick counts; requester i occupies bits [i*N +: N]; value X means wait X timer ticks.
- Grant  output  NREQ  one-hot; the current owner of the timer.
- Done  output  NREQ  one-cycle pulse at the owner's index when its wait expires.
- Busy  output  1  high when in any state other than IDLE.
- Owner  output  IW  index of the current or most recent owner.
- Tmr_load  output  N  drives Timer Load; registered value X-1.
- Tmr_rst  output  1  drives Timer Rst; one-cycle load/clear strobe.
- Tmr_en  output  1  drives Timer En.
- Tmr_end  input  1  Timer End.

Behaviour:
- Reset (Rst=0, asynchronous) clears everything:
  - state = IDLE; RR pointer = 0;
  - Grant = 0, Done = 0, Busy = 0, Owner = 0;
  - Tmr_load = 0, Tmr_rst = 0, Tmr_en = 0.
- Pwr_off=1 at a clock edge gives the same values as reset, synchronously, and takes priority over all transitions. RR pointer is cleared.
- All outputs are registered.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If Req != 0, the winner is the first set bit at or above the RR pointer, wrapping to bit 0.
  - Register Grant = onehot(winner), Owner = winner, Busy = 1.
  - Register Tmr_load = Ticks[winner] - 1 (N-bit, modulo 2^N).
  - Go to LOAD, or to DONE if Ticks[winner] == 0.
  - If Req == 0, remain in IDLE.
- Ticks is sampled only on the IDLE->LOAD transition; later changes are ignored.
- LOAD:
  - Tmr_rst = 1 for exactly one cycle, which loads the timer register and clears its counter.
  - Tmr_en = 0. Next state is RUN.
- RUN:
  - Tmr_en = 1.
  - If Tmr_end = 1, go to DONE and drop Tmr_en in that same registered update.
  - If Req[Owner] = 0 (abandon), go to IDLE with no Done pulse. Grant clears, Busy clears, and the RR pointer becomes Owner+1 (mod NREQ).
  - If abandon and Tmr_end occur in the same cycle, abandon wins and no Done is issued.
  - Tmr_end is ignored in every state except RUN.
- DONE:
  - Done[Owner] = 1 for one cycle; Grant = 0; Busy = 0; Tmr_en = 0.
  - RR pointer becomes Owner+1 (mod NREQ). Next state is IDLE.
- Latency:
  - Req to Grant: 1 cycle from an IDLE sample.
  - Tmr_rst pulse: 1 cycle after Grant.
  - Done: rises 1 cycle after the cycle in which Tmr_end is seen high in RUN.
  - Ticks == 0: Done 1 cycle after Grant, and the timer is never touched.
- A requester holding Req after Done is re-arbitrated in IDLE behind any other pending requesters. This gives fair periodic operation.
- Req of non-owners has no effect outside IDLE.
- Owner keeps its last value after DONE or abandon; Grant is the authoritative ownership signal.
- Invariants:
  - Grant is always one-hot or zero.
  - Done is never asserted while Grant is asserted.
  - Tmr_rst and Tmr_en are never high together.

Test Plan:
- Reset mid-RUN: Req=0001, Ticks0=5; drop Rst during RUN -> all outputs 0 immediately, before the next clock edge; state IDLE.
- Single request: Req=0001, Ticks0=5 (Tmr_load=4), paired with a Timer model -> Grant=0001 at cycle 1, Tmr_rst at cycle 2, Tmr_en high until End, then Done=0001 one cycle later; expected Done-to-Grant distance is 5 ticks plus fixed overhead.
- Round-robin fairness: Req=1111 held with Ticks=3 each -> Grant sequence 0001, 0010, 0100, 1000, 0001; each Done pulse is exactly 1 cycle wide.
- Abandon: Req=0010, Ticks1=100; drop Req1 after 10 RUN cycles -> IDLE next cycle, Done stays 0, pointer=2; a subsequent Req=0011 grants index 0 (wrap from pointer 2, skipping 2 and 3).
- Zero ticks: Req=0100, Ticks2=0 -> Grant=0100, next cycle Done=0100; Tmr_rst and Tmr_en never assert.
- Pwr_off and simultaneous events:
  - Pwr_off=1 in LOAD -> IDLE next edge, Tmr_rst=0.
  - Abandon together with Tmr_end in RUN -> no Done.
  - Tmr_end pulsed while in IDLE -> ignored.

Source files
------------

// File: rtl/timer_sched.sv
// timer_sched: shares one external Timer between NREQ requesters.
// Round-robin arbitration in IDLE, then LOAD (one-cycle timer load strobe),
// RUN (timer enabled until End or abandon) and DONE (one-cycle completion
// pulse at the owner's index). Every output is a register.
module timer_sched #(
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Pwr_off,
  input  logic [NREQ-1:0]   Req,
  input  logic [NREQ*N-1:0] Ticks,
  output logic [NREQ-1:0]   Grant,
  output logic [NREQ-1:0]   Done,
  output logic              Busy,
  output logic [IW-1:0]     Owner,
  output logic [N-1:0]      Tmr_load,
  output logic              Tmr_rst,
  output logic              Tmr_en,
  input  logic              Tmr_end
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;
  logic [N-1:0]    load_q, load_d;
  logic            trst_q, trst_d;
  logic            ten_q, ten_d;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [N-1:0]    win_ticks;
  logic [IW-1:0]   next_ptr;

  // Round-robin pick: first pass looks at or above the pointer, second pass
  // wraps to bit 0. The winner's tick count is captured alongside its index.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_ticks = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_found && Req[k] && (k >= int'(rr_q))) begin
        win_found = 1'b1;
        win_idx   = IW'(k);
        win_ticks = Ticks[k*N +: N];
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (!win_found && Req[k]) begin
        win_found = 1'b1;
        win_idx   = IW'(k);
        win_ticks = Ticks[k*N +: N];
      end
    end
  end

  // Pointer moves just past the finishing owner, wrapping at NREQ.
  assign next_ptr = (int'(owner_q) == NREQ - 1) ? '0 : owner_q + 1'b1;

  // Sequencer: outputs are computed here and registered on the same edge
  // as the state change; Pwr_off overrides everything.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    done_d  = '0;
    busy_d  = busy_q;
    load_d  = load_q;
    trst_d  = 1'b0;
    ten_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d = NREQ'(1) << win_idx;
          owner_d = win_idx;
          busy_d  = 1'b1;
          load_d  = win_ticks - N'(1);
          // A zero wait skips the timer entirely.
          state_d = (win_ticks == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        trst_d  = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        // Abandon beats a simultaneous End: no completion is reported.
        if (!Req[owner_q]) begin
          grant_d = '0;
          busy_d  = 1'b0;
          rr_d    = next_ptr;
          state_d = S_IDLE;
        end else if (Tmr_end) begin
          state_d = S_DONE;
        end else begin
          ten_d = 1'b1;
        end
      end
      S_DONE: begin
        done_d  = NREQ'(1) << owner_q;
        grant_d = '0;
        busy_d  = 1'b0;
        rr_d    = next_ptr;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (Pwr_off) begin
      state_d = S_IDLE;
      rr_d    = '0;
      owner_d = '0;
      grant_d = '0;
      done_d  = '0;
      busy_d  = 1'b0;
      load_d  = '0;
      trst_d  = 1'b0;
      ten_d   = 1'b0;
    end
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      load_q  <= '0;
      trst_q  <= 1'b0;
      ten_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      load_q  <= load_d;
      trst_q  <= trst_d;
      ten_q   <= ten_d;
    end
  end

  assign Grant    = grant_q;
  assign Done     = done_q;
  assign Busy     = busy_q;
  assign Owner    = owner_q;
  assign Tmr_load = load_q;
  assign Tmr_rst  = trst_q;
  assign Tmr_en   = ten_q;

endmodule

// File: tb/tb_timer_sched.sv
// Bench for timer_sched: a behavioural Timer model closes the loop, and a
// transaction-level reference (round-robin pick plus wait-length latency
// formula) predicts grants and completion timing.
module tb_timer_sched;
  localparam int N    = 32;
  localparam int NREQ = 4;
  localparam int IW   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pwr_off;
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] ticks;
  logic [NREQ-1:0]   grant, done;
  logic              busy;
  logic [IW-1:0]     owner;
  logic [N-1:0]      tmr_load;
  logic              tmr_rst, tmr_en, tmr_end;
  logic              end_inj;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int ptr;
  int inv_bad  = 0;
  int rst_cnt, en_cnt, rst_cyc;
  logic [3:0] done_acc;

  always #5 clk = ~clk;

  timer_sched #(.N(N), .NREQ(NREQ), .IW(IW)) dut (
    .Clk(clk), .Rst(rst_n), .Pwr_off(pwr_off), .Req(req), .Ticks(ticks),
    .Grant(grant), .Done(done), .Busy(busy), .Owner(owner),
    .Tmr_load(tmr_load), .Tmr_rst(tmr_rst), .Tmr_en(tmr_en), .Tmr_end(tmr_end)
  );

  // Timer model: Rst loads the limit and clears the count; End is raised
  // while enabled and the count has reached the limit.
  logic [N-1:0] tm_cnt  = '0;
  logic [N-1:0] tm_load = '0;
  always @(posedge clk) begin
    if (tmr_rst) begin
      tm_cnt  <= '0;
      tm_load <= tmr_load;
    end else if (tmr_en) begin
      tm_cnt <= (tm_cnt == tm_load) ? '0 : tm_cnt + 1;
    end
  end
  assign tmr_end = (tmr_en && (tm_cnt == tm_load)) || end_inj;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference arbitration: first requester at or after p, wrapping.
  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  // Advance to the next falling edge and accumulate observations.
  task automatic tick();
    @(negedge clk);
    if ((grant & (grant - 4'd1)) != 4'd0) inv_bad++;
    if ((done & grant) != 4'd0) inv_bad++;
    if (tmr_rst && tmr_en) inv_bad++;
    if (tmr_rst) begin rst_cnt++; rst_cyc = cyc; end
    if (tmr_en) en_cnt++;
    done_acc = done_acc | done;
  endtask

  task automatic wait_grant(output int c);
    c = -1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (grant != 4'd0) begin c = cyc; break; end
    end
  endtask

  task automatic wait_done(output int c);
    c = -1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (done != 4'd0) begin c = cyc; break; end
    end
  endtask

  task automatic test_reset();
    int g;
    rst_n = 1'b0; pwr_off = 1'b0; req = '0; ticks = '0; end_inj = 1'b0;
    done_acc = '0; rst_cnt = 0; en_cnt = 0; rst_cyc = -1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({grant, done, busy, owner, tmr_load, tmr_rst, tmr_en} !== '0)
      $display("FAIL reset_outputs: got g=%b d=%b b=%b o=%0d l=%0h r=%b e=%b want all 0",
               grant, done, busy, owner, tmr_load, tmr_rst, tmr_en);
    else n_pass++;
    rst_n = 1'b1; ptr = 0;
    req = 4'b0001; ticks[0 +: N] = N'(5);
    wait_grant(g);
    for (int i = 0; i < 20 && !tmr_en; i++) tick();
    n_checks++;
    if (tmr_en !== 1'b1) $display("FAIL reset_run_reached: tmr_en=%b want 1", tmr_en);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({grant, done, busy, owner, tmr_load, tmr_rst, tmr_en} !== '0)
      $display("FAIL reset_async: got g=%b b=%b l=%0h e=%b want all 0", grant, busy, tmr_load, tmr_en);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1; req = '0; ptr = 0;
    tick();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_idle: busy=%b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_single();
    int c0, g, d;
    req = 4'b0001; ticks[0 +: N] = N'(5); c0 = cyc;
    rst_cnt = 0; en_cnt = 0; rst_cyc = -1;
    wait_grant(g);
    n_checks++;
    if (g !== c0 + 1) $display("FAIL single_grant_latency: got cycle %0d want %0d", g, c0 + 1);
    else n_pass++;
    n_checks++;
    if ({grant, owner, busy, tmr_load} !== {4'b0001, 2'd0, 1'b1, 32'd4})
      $display("FAIL single_grant: g=%b o=%0d b=%b l=%0d want 0001 0 1 4", grant, owner, busy, tmr_load);
    else n_pass++;
    wait_done(d);
    n_checks++;
    if (rst_cyc !== g + 1) $display("FAIL single_rst_cycle: got %0d want %0d", rst_cyc, g + 1);
    else n_pass++;
    n_checks++;
    if (d - g !== 8) $display("FAIL single_done_latency: got %0d want 8", d - g);
    else n_pass++;
    n_checks++;
    if ({done, grant, busy} !== {4'b0001, 4'b0000, 1'b0})
      $display("FAIL single_done: d=%b g=%b b=%b want 0001 0000 0", done, grant, busy);
    else n_pass++;
    n_checks++;
    if (en_cnt !== 5 || rst_cnt !== 1)
      $display("FAIL single_timer_use: en=%0d rst=%0d want 5 1", en_cnt, rst_cnt);
    else n_pass++;
    req = '0; ptr = 1;
    tick();
    n_checks++;
    if (done !== 4'b0000) $display("FAIL single_done_width: done=%b want 0000", done);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int t[4];
    int g, d, d_prev, w, lat;
    logic [3:0] eg;
    pwr_off = 1'b1; tick(); pwr_off = 1'b0; ptr = 0;
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin t[i] = 3; ticks[i*N +: N] = N'(t[i]); end
    d_prev = -1;
    for (int r = 0; r < 15; r++) begin
      w = pick(req, ptr); eg = 4'b0001 << w;
      rst_cnt = 0; en_cnt = 0;
      wait_grant(g);
      n_checks++;
      if (grant !== eg || owner !== IW'(w))
        $display("FAIL rr_grant[%0d]: g=%b o=%0d want %b %0d (req=%b)", r, grant, owner, eg, w, req);
      else n_pass++;
      if (d_prev >= 0) begin
        n_checks++;
        if (g !== d_prev + 1 || done !== 4'b0000)
          $display("FAIL rr_regrant[%0d]: grant cycle %0d done=%b want %0d 0000", r, g, done, d_prev + 1);
        else n_pass++;
      end
      wait_done(d);
      lat = (t[w] == 0) ? 1 : t[w] + 3;
      n_checks++;
      if (done !== eg || d - g !== lat)
        $display("FAIL rr_done[%0d]: d=%b lat=%0d want %b %0d", r, done, d - g, eg, lat);
      else n_pass++;
      n_checks++;
      if (en_cnt !== t[w] || rst_cnt !== ((t[w] == 0) ? 0 : 1))
        $display("FAIL rr_timer_use[%0d]: en=%0d rst=%0d want %0d %0d", r, en_cnt, rst_cnt,
                 t[w], (t[w] == 0) ? 0 : 1);
      else n_pass++;
      ptr = (w + 1) % NREQ; d_prev = d;
      if (r == 14) req = '0;
      else if (r >= 4) begin
        req = 4'($urandom_range(1, 15));
        for (int i = 0; i < NREQ; i++) begin
          t[i] = int'($urandom_range(0, 6)); ticks[i*N +: N] = N'(t[i]);
        end
      end
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 4'b0000) $display("FAIL rr_end_idle: b=%b d=%b want 0 0000", busy, done);
    else n_pass++;
  endtask

  task automatic test_abandon();
    int g, d, w;
    req = 4'b0010; ticks[1*N +: N] = N'(100);
    wait_grant(g);
    n_checks++;
    if (grant !== 4'b0010) $display("FAIL abandon_grant: g=%b want 0010", grant);
    else n_pass++;
    for (int i = 0; i < 20 && !tmr_en; i++) tick();
    repeat (10) tick();
    req = '0; done_acc = '0;
    tick();
    n_checks++;
    if ({busy, grant, done} !== 9'd0) $display("FAIL abandon_idle: b=%b g=%b d=%b want 0", busy, grant, done);
    else n_pass++;
    ptr = 2;
    req = 4'b0011; ticks[0 +: N] = N'(2);
    w = pick(req, ptr);
    wait_grant(g);
    n_checks++;
    if (grant !== (4'b0001 << w)) $display("FAIL abandon_ptr: g=%b want index %0d", grant, w);
    else n_pass++;
    n_checks++;
    if (done_acc !== 4'b0000) $display("FAIL abandon_no_done: done seen %b want 0000", done_acc);
    else n_pass++;
    wait_done(d);
    n_checks++;
    if (done !== 4'b0001 || d - g !== 5) $display("FAIL abandon_next_done: d=%b lat=%0d want 0001 5", done, d - g);
    else n_pass++;
    req = '0; ptr = 1;
  endtask

  task automatic test_zero_ticks();
    int g, d;
    req = 4'b0100; ticks[2*N +: N] = '0; rst_cnt = 0; en_cnt = 0;
    wait_grant(g);
    n_checks++;
    if (grant !== 4'b0100) $display("FAIL zero_grant: g=%b want 0100", grant);
    else n_pass++;
    wait_done(d);
    n_checks++;
    if (done !== 4'b0100 || d !== g + 1) $display("FAIL zero_done: d=%b lat=%0d want 0100 1", done, d - g);
    else n_pass++;
    n_checks++;
    if (rst_cnt !== 0 || en_cnt !== 0) $display("FAIL zero_timer_idle: rst=%0d en=%0d want 0 0", rst_cnt, en_cnt);
    else n_pass++;
    req = '0; ptr = 3;
  endtask

  task automatic test_pwr_off();
    int g, d;
    req = 4'b0100; ticks[2*N +: N] = N'(5);
    wait_grant(g);
    n_checks++;
    if (owner !== 2'd2 || tmr_load !== 32'd4) $display("FAIL pwr_pre: o=%0d l=%0d want 2 4", owner, tmr_load);
    else n_pass++;
    pwr_off = 1'b1;
    tick();
    n_checks++;
    if ({grant, done, busy, owner, tmr_load, tmr_rst, tmr_en} !== '0)
      $display("FAIL pwr_off_clear: g=%b b=%b o=%0d l=%0d r=%b want all 0", grant, busy, owner, tmr_load, tmr_rst);
    else n_pass++;
    pwr_off = 1'b0; req = '0; ptr = 0;
    tick();
    req = 4'b1010; ticks[1*N +: N] = N'(1);
    wait_grant(g);
    n_checks++;
    if (grant !== 4'b0010) $display("FAIL pwr_ptr_cleared: g=%b want 0010", grant);
    else n_pass++;
    wait_done(d);
    n_checks++;
    if (done !== 4'b0010 || d - g !== 4) $display("FAIL pwr_next_done: d=%b lat=%0d want 0010 4", done, d - g);
    else n_pass++;
    req = '0; ptr = 2;
  endtask

  task automatic test_abandon_with_end();
    int g;
    req = 4'b0001; ticks[0 +: N] = N'(50);
    wait_grant(g);
    for (int i = 0; i < 20 && !tmr_en; i++) tick();
    repeat (3) tick();
    req = '0; end_inj = 1'b1; done_acc = '0;
    tick();
    end_inj = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (busy !== 1'b0 || done_acc !== 4'b0000)
      $display("FAIL abandon_end: b=%b done seen %b want 0 0000", busy, done_acc);
    else n_pass++;
    ptr = 1;
  endtask

  task automatic test_end_in_idle();
    int g, d;
    end_inj = 1'b1; done_acc = '0;
    repeat (3) tick();
    n_checks++;
    if (busy !== 1'b0 || tmr_en !== 1'b0 || done_acc !== 4'b0000)
      $display("FAIL idle_end_ignored: b=%b e=%b done seen %b want 0 0 0000", busy, tmr_en, done_acc);
    else n_pass++;
    end_inj = 1'b0;
    req = 4'b1000; ticks[3*N +: N] = N'(2);
    wait_grant(g);
    n_checks++;
    if (grant !== (4'b0001 << pick(4'b1000, ptr))) $display("FAIL idle_end_grant: g=%b want 1000", grant);
    else n_pass++;
    wait_done(d);
    n_checks++;
    if (done !== 4'b1000 || d - g !== 5) $display("FAIL idle_end_done: d=%b lat=%0d want 1000 5", done, d - g);
    else n_pass++;
    req = '0; ptr = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_abandon();
    test_zero_ticks();
    test_pwr_off();
    test_abandon_with_end();
    test_end_in_idle();
    n_checks++;
    if (inv_bad !== 0) $display("FAIL invariants: %0d violations want 0", inv_bad);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
